// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: captures decoded operands, resolves RAW hazards, holds porta/portb/ALUOp
// on a valid/ready handshake. Define ALU_ISSUE_FWD_EN for forwarding; otherwise hazards stall.
module alu_issue_stage #(
   parameter int DW      = 64,
   parameter int ALUOP_W = 4,
   parameter int RW      = 5
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [RW-1:0]      in_rs1,
   input  logic [RW-1:0]      in_rs2,
   input  logic [DW-1:0]      in_rdata1,
   input  logic [DW-1:0]      in_rdata2,
   input  logic [DW-1:0]      in_imm,
   input  logic [DW-1:0]      in_pc,
   input  logic               in_asel,
   input  logic               in_bsel,
   input  logic [ALUOP_W-1:0] in_aluop,
   input  logic [RW-1:0]      in_rd,
   input  logic               in_regwen,
   input  logic               ex_wen,
   input  logic [RW-1:0]      ex_rd,
   input  logic [DW-1:0]      ex_data,
   input  logic               wb_wen,
   input  logic [RW-1:0]      wb_rd,
   input  logic [DW-1:0]      wb_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DW-1:0]      porta,
   output logic [DW-1:0]      portb,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic [RW-1:0]      out_rd,
   output logic               out_regwen
);

   logic               valid_q, valid_d;
   logic [DW-1:0]      porta_q, porta_d;
   logic [DW-1:0]      portb_q, portb_d;
   logic [ALUOP_W-1:0] aluop_q, aluop_d;
   logic [RW-1:0]      rd_q, rd_d;
   logic               regwen_q, regwen_d;

   logic [DW-1:0] src1, src2;
   logic          hazard;
   logic          capture;

`ifdef ALU_ISSUE_FWD_EN
   // EX is the younger producer, so it wins over WB; x0 is hardwired and never forwarded.
   function automatic logic [DW-1:0] fwd(
      input logic [RW-1:0] rs,
      input logic [DW-1:0] rdata,
      input logic          e_wen,
      input logic [RW-1:0] e_rd,
      input logic [DW-1:0] e_data,
      input logic          w_wen,
      input logic [RW-1:0] w_rd,
      input logic [DW-1:0] w_data
   );
      if (e_wen && e_rd == rs && rs != '0)      return e_data;
      else if (w_wen && w_rd == rs && rs != '0) return w_data;
      else                                      return rdata;
   endfunction

   always_comb begin
      src1   = fwd(in_rs1, in_rdata1, ex_wen, ex_rd, ex_data, wb_wen, wb_rd, wb_data);
      src2   = fwd(in_rs2, in_rdata2, ex_wen, ex_rd, ex_data, wb_wen, wb_rd, wb_data);
      hazard = 1'b0;
   end
`else
   logic hit1, hit2;
   logic unused_fwd_data;

   always_comb begin
      src1   = in_rdata1;
      src2   = in_rdata2;
      hit1   = in_rs1 != '0 && ((ex_wen && ex_rd == in_rs1) || (wb_wen && wb_rd == in_rs1));
      hit2   = in_rs2 != '0 && ((ex_wen && ex_rd == in_rs2) || (wb_wen && wb_rd == in_rs2));
      hazard = in_valid && ((!in_asel && hit1) || (!in_bsel && hit2));
   end

   assign unused_fwd_data = ^{ex_data, wb_data};
`endif

   always_comb begin
      in_ready = !RST && !flush && (!valid_q || out_ready) && !hazard;
      capture  = in_valid && in_ready;

      valid_d  = valid_q;
      porta_d  = porta_q;
      portb_d  = portb_q;
      aluop_d  = aluop_q;
      rd_d     = rd_q;
      regwen_d = regwen_q;

      if (flush) begin
         valid_d  = 1'b0;
         regwen_d = 1'b0;
      end else if (capture) begin
         valid_d  = 1'b1;
         porta_d  = in_asel ? in_pc  : src1;
         portb_d  = in_bsel ? in_imm : src2;
         aluop_d  = in_aluop;
         rd_d     = in_rd;
         regwen_d = in_regwen;
      end else if (valid_q && out_ready) begin
         valid_d  = 1'b0;
         regwen_d = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         valid_q  <= 1'b0;
         porta_q  <= '0;
         portb_q  <= '0;
         aluop_q  <= '0;
         rd_q     <= '0;
         regwen_q <= 1'b0;
      end else begin
         valid_q  <= valid_d;
         porta_q  <= porta_d;
         portb_q  <= portb_d;
         aluop_q  <= aluop_d;
         rd_q     <= rd_d;
         regwen_q <= regwen_d;
      end
   end

   assign out_valid  = valid_q;
   assign porta      = porta_q;
   assign portb      = portb_q;
   assign ALUOp      = aluop_q;
   assign out_rd     = rd_q;
   assign out_regwen = regwen_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage; forwarding checks follow ALU_ISSUE_FWD_EN.
module tb_alu_issue_stage;
   logic        CLK, RST, flush, in_valid, in_ready;
   logic [4:0]  in_rs1, in_rs2, in_rd, ex_rd, wb_rd, out_rd;
   logic [63:0] in_rdata1, in_rdata2, in_imm, in_pc, ex_data, wb_data, porta, portb;
   logic        in_asel, in_bsel, in_regwen, ex_wen, wb_wen, out_valid, out_ready, out_regwen;
   logic [3:0]  in_aluop, ALUOp;

   typedef struct packed {
      logic [63:0] a;
      logic [63:0] b;
      logic [3:0]  op;
      logic [4:0]  rd;
      logic        regwen;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   pushed = 0;
   int   popped = 0;

   alu_issue_stage dut (
      .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rdata1(in_rdata1), .in_rdata2(in_rdata2),
      .in_imm(in_imm), .in_pc(in_pc), .in_asel(in_asel), .in_bsel(in_bsel),
      .in_aluop(in_aluop), .in_rd(in_rd), .in_regwen(in_regwen),
      .ex_wen(ex_wen), .ex_rd(ex_rd), .ex_data(ex_data),
      .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready), .porta(porta), .portb(portb),
      .ALUOp(ALUOp), .out_rd(out_rd), .out_regwen(out_regwen)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [63:0] rd1, input logic [63:0] rd2,
                        input logic [63:0] imm, input logic [63:0] pc,
                        input logic asel, input logic bsel, input logic [3:0] op,
                        input logic [4:0] rd, input logic wen);
      in_valid = 1'b1;
      in_rs1 = rs1; in_rs2 = rs2; in_rdata1 = rd1; in_rdata2 = rd2;
      in_imm = imm; in_pc = pc; in_asel = asel; in_bsel = bsel;
      in_aluop = op; in_rd = rd; in_regwen = wen;
   endtask

   task automatic push(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op,
                       input logic [4:0] rd, input logic wen);
      exp_t e;
      e.a = a; e.b = b; e.op = op; e.rd = rd; e.regwen = wen;
      exp_q.push_back(e);
      pushed++;
   endtask

   task automatic set_buses(input logic ew, input logic [4:0] er, input logic [63:0] ed,
                            input logic ww, input logic [4:0] wr, input logic [63:0] wd);
      ex_wen = ew; ex_rd = er; ex_data = ed;
      wb_wen = ww; wb_rd = wr; wb_data = wd;
   endtask

   // Monitor: every accepted output is popped against the next expected entry.
   always @(negedge CLK) begin
      if (!RST && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_output", 64'(out_valid), 64'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            popped++;
            chk("sb_porta",  porta,           e.a);
            chk("sb_portb",  portb,           e.b);
            chk("sb_aluop",  64'(ALUOp),      64'(e.op));
            chk("sb_rd",     64'(out_rd),     64'(e.rd));
            chk("sb_regwen", 64'(out_regwen), 64'(e.regwen));
         end
      end
   end

   initial begin
      RST = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_rs1 = '0; in_rs2 = '0; in_rdata1 = '0; in_rdata2 = '0; in_imm = '0; in_pc = '0;
      in_asel = 1'b0; in_bsel = 1'b0; in_aluop = '0; in_rd = '0; in_regwen = 1'b0;
      set_buses(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);

      // reset
      tick(); tick();
      chk("rst_out_valid",  64'(out_valid),  64'd0);
      chk("rst_porta",      porta,           64'd0);
      chk("rst_portb",      portb,           64'd0);
      chk("rst_aluop",      64'(ALUOp),      64'd0);
      chk("rst_out_regwen", 64'(out_regwen), 64'd0);
      chk("rst_in_ready",   64'(in_ready),   64'd0);
      RST = 1'b0;
      #1;
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);

      // basic capture, latency 1, drain
      out_ready = 1'b1;
      drive(5'd3, 5'd0, 64'h10, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1, 4'd2, 5'd4, 1'b1);
      push(64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 4'd2, 5'd4, 1'b1);
      tick();
      in_valid = 1'b0;
      chk("cap_out_valid", 64'(out_valid), 64'd1);
      chk("cap_porta",     porta,          64'h10);
      chk("cap_portb",     portb,          64'hFFFF_FFFF_FFFF_FFFF);
      tick();
      chk("drain_out_valid",  64'(out_valid),  64'd0);
      chk("drain_out_regwen", 64'(out_regwen), 64'd0);

      // asel=pc, bsel=rs2 path
      drive(5'd1, 5'd9, 64'h1, 64'h55, 64'h0, 64'h1000, 1'b1, 1'b0, 4'd7, 5'd12, 1'b0);
      push(64'h1000, 64'h55, 4'd7, 5'd12, 1'b0);
      tick();
      in_valid = 1'b0;
      tick();

`ifdef ALU_ISSUE_FWD_EN
      // EX beats WB on rs1, back-to-back captures
      set_buses(1'b1, 5'd5, 64'hAA, 1'b1, 5'd5, 64'hBB);
      drive(5'd5, 5'd0, 64'h0, 64'h0, 64'h1, 64'h0, 1'b0, 1'b1, 4'd1, 5'd2, 1'b1);
      #1;
      chk("fwd_no_stall", 64'(in_ready), 64'd1);
      push(64'hAA, 64'h1, 4'd1, 5'd2, 1'b1);
      tick();
      // WB only on rs2
      set_buses(1'b1, 5'd5, 64'hAA, 1'b1, 5'd6, 64'hBB);
      drive(5'd1, 5'd6, 64'h21, 64'h99, 64'h0, 64'h0, 1'b0, 1'b0, 4'd3, 5'd8, 1'b1);
      push(64'h21, 64'hBB, 4'd3, 5'd8, 1'b1);
      tick();
      // x0 never forwarded
      set_buses(1'b1, 5'd0, 64'hAA, 1'b1, 5'd0, 64'hBB);
      drive(5'd0, 5'd0, 64'h33, 64'h44, 64'h0, 64'h0, 1'b0, 1'b0, 4'd4, 5'd9, 1'b1);
      push(64'h33, 64'h44, 4'd4, 5'd9, 1'b1);
      tick();
      in_valid = 1'b0;
      tick();
`else
      // stall on WB hazard for used rs2, clears once rs2 unused
      set_buses(1'b0, 5'd0, 64'h0, 1'b1, 5'd7, 64'hBB);
      drive(5'd1, 5'd7, 64'h11, 64'h22, 64'h5, 64'h0, 1'b0, 1'b0, 4'd6, 5'd3, 1'b1);
      #1;
      chk("haz_wb_rs2", 64'(in_ready), 64'd0);
      in_bsel = 1'b1;
      #1;
      chk("haz_rs2_unused", 64'(in_ready), 64'd1);
      push(64'h11, 64'h5, 4'd6, 5'd3, 1'b1);
      tick();
      // EX hazard on rs1, x0 exempt
      set_buses(1'b1, 5'd3, 64'hAA, 1'b0, 5'd0, 64'h0);
      drive(5'd3, 5'd0, 64'h66, 64'h0, 64'h8, 64'h0, 1'b0, 1'b1, 4'd5, 5'd4, 1'b0);
      #1;
      chk("haz_ex_rs1", 64'(in_ready), 64'd0);
      in_rs1 = 5'd0;
      ex_rd = 5'd0;
      #1;
      chk("haz_x0_exempt", 64'(in_ready), 64'd1);
      push(64'h66, 64'h8, 4'd5, 5'd4, 1'b0);
      tick();
      in_valid = 1'b0;
      tick();
`endif
      set_buses(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);

      // stall for 3 cycles, then drain+capture on the same edge
      out_ready = 1'b0;
      drive(5'd2, 5'd0, 64'hA1, 64'h0, 64'hB1, 64'h0, 1'b0, 1'b1, 4'd8, 5'd10, 1'b1);
      push(64'hA1, 64'hB1, 4'd8, 5'd10, 1'b1);
      tick();
      drive(5'd2, 5'd0, 64'hA2, 64'h0, 64'hB2, 64'h0, 1'b0, 1'b1, 4'd9, 5'd11, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_in_ready", 64'(in_ready), 64'd0);
         tick();
         chk("stall_valid", 64'(out_valid), 64'd1);
         chk("stall_porta", porta,          64'hA1);
         chk("stall_aluop", 64'(ALUOp),     64'd8);
      end
      out_ready = 1'b1;
      #1;
      chk("unstall_in_ready", 64'(in_ready), 64'd1);
      push(64'hA2, 64'hB2, 4'd9, 5'd11, 1'b0);
      tick();
      in_valid = 1'b0;
      chk("replace_valid", 64'(out_valid), 64'd1);
      chk("replace_porta", porta,          64'hA2);
      tick();

      // flush kills held and incoming instructions
      out_ready = 1'b0;
      drive(5'd1, 5'd0, 64'hC1, 64'h0, 64'hC2, 64'h0, 1'b0, 1'b1, 4'd3, 5'd13, 1'b1);
      tick();
      chk("pre_flush_valid", 64'(out_valid), 64'd1);
      drive(5'd1, 5'd0, 64'hD1, 64'h0, 64'hD2, 64'h0, 1'b0, 1'b1, 4'd4, 5'd14, 1'b1);
      flush = 1'b1;
      #1;
      chk("flush_in_ready", 64'(in_ready), 64'd0);
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_out_valid",  64'(out_valid),  64'd0);
      chk("flush_out_regwen", 64'(out_regwen), 64'd0);
      out_ready = 1'b1;
      tick(); tick();

      chk("sb_drained", 64'(exp_q.size()), 64'd0);
      chk("sb_count",   64'(popped),       64'(pushed));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
